// File: rtl/keyboard_view_control.sv
// PS/2 key activity to Mandelbrot viewport commands: pan, zoom and reset with
// typematic auto-repeat, delivered to the renderer over a valid/ready handshake.
module keyboard_view_control #(
    parameter int                      COORD_WIDTH   = 32,
    parameter int                      ZOOM_WIDTH    = 5,
    parameter int                      ZOOM_MAX      = 24,
    parameter logic [COORD_WIDTH-1:0]  PAN_BASE      = 32'h0100_0000,
    parameter logic [COORD_WIDTH-1:0]  INIT_X        = -32'sh0800_0000,
    parameter logic [COORD_WIDTH-1:0]  INIT_Y        = '0,
    parameter logic [ZOOM_WIDTH-1:0]   INIT_ZOOM     = '0,
    parameter int unsigned             REPEAT_DELAY  = 25_000_000,
    parameter int unsigned             REPEAT_PERIOD = 5_000_000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [255:0]           keytable_in,
    input  logic [7:0]             keyevent_in,
    output logic [COORD_WIDTH-1:0] center_x,
    output logic [COORD_WIDTH-1:0] center_y,
    output logic [ZOOM_WIDTH-1:0]  zoom_level,
    output logic                   view_valid,
    input  logic                   view_ready
);

    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_Q = 8'h15;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_R = 8'h2D;

    localparam logic [ZOOM_WIDTH-1:0]  ZOOM_TOP  = ZOOM_WIDTH'(ZOOM_MAX);
    localparam logic [ZOOM_WIDTH-1:0]  ZOOM_ONE  = ZOOM_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] STEP_MIN  = COORD_WIDTH'(1);
    localparam logic [COORD_WIDTH-1:0] COORD_MAX = {1'b0, {(COORD_WIDTH-1){1'b1}}};
    localparam logic [COORD_WIDTH-1:0] COORD_MIN = {1'b1, {(COORD_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t                 state, state_nx;
    logic [7:0]             active_key, key_nx;
    logic [31:0]            counter, cnt_nx;
    logic                   slot_valid, slot_valid_nx;
    logic [7:0]             slot_key, slot_key_nx;
    logic                   due;
    logic [7:0]             due_key;
    logic                   pend, stall, changed, apply, valid_nx;
    logic [7:0]             pend_key;
    logic [COORD_WIDTH-1:0] step_raw, step, nx, ny;
    logic [ZOOM_WIDTH-1:0]  nz;

    function automatic logic is_mapped(input logic [7:0] code);
        case (code)
            KEY_W, KEY_S, KEY_A, KEY_D, KEY_Q, KEY_E, KEY_R: is_mapped = 1'b1;
            default:                                         is_mapped = 1'b0;
        endcase
    endfunction

    // One extra bit of headroom exposes signed overflow, which then clamps.
    function automatic logic [COORD_WIDTH-1:0] sat_pan(
        input logic [COORD_WIDTH-1:0] base,
        input logic [COORD_WIDTH-1:0] delta,
        input logic                   negative
    );
        logic [COORD_WIDTH:0] wide;
        wide = negative ? {base[COORD_WIDTH-1], base} - {1'b0, delta}
                        : {base[COORD_WIDTH-1], base} + {1'b0, delta};
        if (wide[COORD_WIDTH] != wide[COORD_WIDTH-1])
            sat_pan = wide[COORD_WIDTH] ? COORD_MIN : COORD_MAX;
        else
            sat_pan = wide[COORD_WIDTH-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        key_nx   = active_key;
        cnt_nx   = counter;
        due      = 1'b0;
        due_key  = '0;
        if (is_mapped(keyevent_in)) begin
            due     = 1'b1;
            due_key = keyevent_in;
            if (keyevent_in == KEY_R) begin
                state_nx = IDLE;
            end else begin
                key_nx   = keyevent_in;
                cnt_nx   = REPEAT_DELAY;
                state_nx = DELAY;
            end
        end else if (state != IDLE) begin
            if (!keytable_in[active_key]) begin
                state_nx = IDLE;
            end else if (counter <= 32'd1) begin
                due      = 1'b1;
                due_key  = active_key;
                cnt_nx   = REPEAT_PERIOD;
                state_nx = REPEAT;
            end else begin
                cnt_nx = counter - 32'd1;
            end
        end
    end

    // A fresh action always wins over an older deferred one.
    always_comb begin
        stall    = view_valid & ~view_ready;
        pend     = due | slot_valid;
        pend_key = due ? due_key : slot_key;
        step_raw = PAN_BASE >> zoom_level;
        step     = (step_raw == '0) ? STEP_MIN : step_raw;
        nx       = center_x;
        ny       = center_y;
        nz       = zoom_level;
        case (pend_key)
            KEY_W: ny = sat_pan(center_y, step, 1'b0);
            KEY_S: ny = sat_pan(center_y, step, 1'b1);
            KEY_A: nx = sat_pan(center_x, step, 1'b1);
            KEY_D: nx = sat_pan(center_x, step, 1'b0);
            KEY_Q: if (zoom_level < ZOOM_TOP) nz = zoom_level + ZOOM_ONE;
            KEY_E: if (zoom_level != '0)      nz = zoom_level - ZOOM_ONE;
            KEY_R: begin
                nx = INIT_X;
                ny = INIT_Y;
                nz = INIT_ZOOM;
            end
            default: ;
        endcase
        changed       = {nx, ny, nz} != {center_x, center_y, zoom_level};
        apply         = pend & ~stall & changed;
        slot_valid_nx = stall & pend;
        slot_key_nx   = (stall & due) ? due_key : slot_key;
        valid_nx      = apply | stall;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            active_key <= '0;
            counter    <= '0;
            slot_valid <= 1'b0;
            slot_key   <= '0;
            center_x   <= INIT_X;
            center_y   <= INIT_Y;
            zoom_level <= INIT_ZOOM;
            view_valid <= 1'b1;
        end else begin
            state      <= state_nx;
            active_key <= key_nx;
            counter    <= cnt_nx;
            slot_valid <= slot_valid_nx;
            slot_key   <= slot_key_nx;
            view_valid <= valid_nx;
            if (apply) begin
                center_x   <= nx;
                center_y   <= ny;
                zoom_level <= nz;
            end
        end
    end

endmodule

// File: tb/tb_keyboard_view_control.sv
// Bench for keyboard_view_control: directed scenarios plus randomized key traffic,
// all compared against a time-stamped behavioural model of the viewport.
module tb_keyboard_view_control;

    localparam int DLY = 10;
    localparam int PER = 4;

    localparam logic [7:0] K_W = 8'h1D, K_S = 8'h1B, K_A = 8'h1C, K_D = 8'h23;
    localparam logic [7:0] K_Q = 8'h15, K_E = 8'h24, K_R = 8'h2D;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [255:0] keytable_in = '0;
    logic [7:0]   keyevent_in = 8'h00;
    logic         view_ready = 1'b1;
    logic [31:0]  center_x, center_y;
    logic [4:0]   zoom_level;
    logic         view_valid;

    wire [69:0] dut_vec = {center_x, center_y, zoom_level, view_valid};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    keyboard_view_control #(
        .REPEAT_DELAY (DLY),
        .REPEAT_PERIOD(PER)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .keytable_in(keytable_in),
        .keyevent_in(keyevent_in),
        .center_x   (center_x),
        .center_y   (center_y),
        .zoom_level (zoom_level),
        .view_valid (view_valid),
        .view_ready (view_ready)
    );

    // Reference model: view as plain integers, repeat timing as absolute cycle stamps.
    longint     mx, my;
    int         mz;
    bit         mv;
    bit         act_on;
    logic [7:0] act_key;
    int         next_fire;
    bit         slot_on;
    logic [7:0] slot_k;
    int         cyc;

    function automatic bit mapped(input logic [7:0] k);
        return k inside {K_W, K_S, K_A, K_D, K_Q, K_E, K_R};
    endfunction

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647)  return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    function automatic logic [69:0] model_vec();
        return {mx[31:0], my[31:0], mz[4:0], mv};
    endfunction

    task automatic model_reset();
        mx = -64'sd134217728; my = 0; mz = 0; mv = 1'b1;
        act_on = 1'b0; slot_on = 1'b0; cyc = 0;
    endtask

    task automatic model_cycle();
        bit         due, pend;
        logic [7:0] dk, pk;
        longint     nx, ny, st;
        int         nz;
        due = 1'b0; dk = 8'h00;
        if (mapped(keyevent_in)) begin
            due = 1'b1; dk = keyevent_in;
            if (keyevent_in == K_R) act_on = 1'b0;
            else begin
                act_on = 1'b1; act_key = keyevent_in; next_fire = cyc + DLY;
            end
        end else if (act_on) begin
            if (!keytable_in[act_key]) act_on = 1'b0;
            else if (cyc == next_fire) begin
                due = 1'b1; dk = act_key; next_fire = cyc + PER;
            end
        end
        if (mv && !view_ready) begin
            if (due) begin slot_on = 1'b1; slot_k = dk; end
        end else begin
            pend = due || slot_on;
            pk   = due ? dk : slot_k;
            slot_on = 1'b0;
            if (mv && view_ready) mv = 1'b0;
            if (pend) begin
                st = 64'sd16777216 >>> mz;
                if (st == 0) st = 1;
                nx = mx; ny = my; nz = mz;
                case (pk)
                    K_W: ny = sat(my + st);
                    K_S: ny = sat(my - st);
                    K_A: nx = sat(mx - st);
                    K_D: nx = sat(mx + st);
                    K_Q: nz = (mz < 24) ? mz + 1 : 24;
                    K_E: nz = (mz > 0) ? mz - 1 : 0;
                    K_R: begin nx = -64'sd134217728; ny = 0; nz = 0; end
                    default: ;
                endcase
                if (nx != mx || ny != my || nz != mz) begin
                    mx = nx; my = ny; mz = nz; mv = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic press_tick(input logic [7:0] k);
        keyevent_in = k;
        keytable_in[k] = 1'b1;
        tick();
        keyevent_in = 8'h00;
    endtask

    task automatic release_tick(input logic [7:0] k);
        keytable_in[k] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (dut_vec !== {32'hF800_0000, 32'h0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, {32'hF800_0000, 32'h0, 5'd0, 1'b1});
        end
        view_ready = 1'b1;
        tick();
        n_checks++;
        if (view_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_accept: got valid=%b expected 0", view_valid);
        end
    endtask

    task automatic test_pan_repeat();
        press_tick(K_D);
        n_checks++;
        if (center_x !== 32'hF900_0000 || view_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pan_press: got x=%h v=%b expected x=f9000000 v=1", center_x, view_valid);
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL pan_hold[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
            if (i == 10) begin
                n_checks++;
                if (center_x !== 32'hFA00_0000 || view_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL pan_first_repeat: got x=%h v=%b expected x=fa000000 v=1", center_x, view_valid);
                end
            end
        end
        n_checks++;
        if (center_x !== 32'hFC00_0000) begin
            n_fail++;
            $display("FAIL pan_repeats: got x=%h expected fc000000", center_x);
        end
        keytable_in[K_D] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (center_x !== 32'hFC00_0000 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL pan_release: got %h expected x=fc000000 model %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_zoom_saturate();
        logic [31:0] x_before;
        for (int i = 0; i < 25; i++) begin
            press_tick(K_Q);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL zoom_press[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
            if (i == 24) begin
                n_checks++;
                if (zoom_level !== 5'd24 || view_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL zoom_top: got z=%0d v=%b expected z=24 v=0", zoom_level, view_valid);
                end
            end
            release_tick(K_Q);
        end
        x_before = center_x;
        press_tick(K_D);
        n_checks++;
        if (center_x !== x_before + 32'd1 || zoom_level !== 5'd24) begin
            n_fail++;
            $display("FAIL zoom_min_step: got x=%h expected %h", center_x, x_before + 32'd1);
        end
        release_tick(K_D);
    endtask

    task automatic test_pan_saturate();
        do_reset();
        tick();
        press_tick(K_D);
        for (int i = 0; i < 1000; i++) begin
            if (mx == 64'sh7F00_0000) break;
            tick();
        end
        n_checks++;
        if (center_x !== 32'h7F00_0000 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL sat_climb: got %h expected x=7f000000 model %h", dut_vec, model_vec());
        end
        release_tick(K_D);
        for (int z = 1; z <= 17; z++) begin
            press_tick(K_Q); release_tick(K_Q);
            press_tick(K_D);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL sat_fine[%0d]: got %h expected %h", z, dut_vec, model_vec());
            end
            release_tick(K_D);
        end
        for (int z = 0; z < 17; z++) begin
            press_tick(K_E); release_tick(K_E);
        end
        n_checks++;
        if (center_x !== 32'h7FFF_FF80 || zoom_level !== 5'd0) begin
            n_fail++;
            $display("FAIL sat_setup: got x=%h z=%0d expected x=7fffff80 z=0", center_x, zoom_level);
        end
        press_tick(K_D);
        n_checks++;
        if (center_x !== 32'h7FFF_FFFF || view_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clamp: got x=%h v=%b expected x=7fffffff v=1", center_x, view_valid);
        end
        release_tick(K_D);
        press_tick(K_D);
        n_checks++;
        if (center_x !== 32'h7FFF_FFFF || view_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_noop: got x=%h v=%b expected x=7fffffff v=0", center_x, view_valid);
        end
        release_tick(K_D);
    endtask

    task automatic test_backpressure();
        view_ready = 1'b0;
        press_tick(K_A);
        n_checks++;
        if (center_x !== 32'h7EFF_FFFF || view_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first: got x=%h v=%b expected x=7effffff v=1", center_x, view_valid);
        end
        release_tick(K_A);
        press_tick(K_S);
        n_checks++;
        if ({center_x, center_y, view_valid} !== {32'h7EFF_FFFF, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_hold: got x=%h y=%h v=%b expected x=7effffff y=0 v=1", center_x, center_y, view_valid);
        end
        keytable_in[K_S] = 1'b0;
        view_ready = 1'b1;
        tick();
        n_checks++;
        if (center_y !== 32'hFF00_0000 || view_valid !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL bp_deferred: got y=%h v=%b expected y=ff000000 v=1", center_y, view_valid);
        end
        tick();
        n_checks++;
        if (view_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b expected 0", view_valid);
        end
    endtask

    task automatic test_reset_key_mid_repeat();
        view_ready = 1'b1;
        press_tick(K_W);
        for (int i = 0; i < 20; i++) tick();
        n_checks++;
        if (dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL rkey_repeat: got %h expected %h", dut_vec, model_vec());
        end
        press_tick(K_R);
        n_checks++;
        if (dut_vec !== {32'hF800_0000, 32'h0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rkey_restore: got %h expected %h", dut_vec, {32'hF800_0000, 32'h0, 5'd0, 1'b1});
        end
        keytable_in[K_R] = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        n_checks++;
        if (center_y !== 32'h0 || view_valid !== 1'b0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL rkey_no_more_steps: got y=%h v=%b expected y=0 v=0", center_y, view_valid);
        end
        release_tick(K_W);
    endtask

    task automatic test_random();
        int         r;
        logic [7:0] code;
        for (int i = 0; i < 3000; i++) begin
            keyevent_in = 8'h00;
            if ($urandom_range(0, 15) == 0) begin
                r = $urandom_range(0, 19);
                case (r)
                    0: code = K_W;  1: code = K_S;  2: code = K_A;
                    3: code = K_D;  4: code = K_Q;  5: code = K_E;
                    6: code = K_R;
                    default: code = 8'($urandom_range(0, 255));
                endcase
                keyevent_in = code;
                if ($urandom_range(0, 3) != 0) keytable_in[code] = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) begin
                r = $urandom_range(0, 5);
                case (r)
                    0: keytable_in[K_W] = 1'b0;  1: keytable_in[K_S] = 1'b0;
                    2: keytable_in[K_A] = 1'b0;  3: keytable_in[K_D] = 1'b0;
                    4: keytable_in[K_Q] = 1'b0;  default: keytable_in[K_E] = 1'b0;
                endcase
            end
            view_ready = ($urandom_range(0, 9) < 7);
            if (i == 1500) begin
                reset_n = 1'b0;
                #1;
                n_checks++;
                if (dut_vec !== {32'hF800_0000, 32'h0, 5'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL async_reset: got %h expected %h", dut_vec, {32'hF800_0000, 32'h0, 5'd0, 1'b1});
                end
                #1;
                reset_n = 1'b1;
                model_reset();
            end
            tick();
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        keyevent_in = 8'h00;
    endtask

    initial begin
        model_reset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        test_reset();
        test_pan_repeat();
        test_zoom_saturate();
        test_pan_saturate();
        test_backpressure();
        test_reset_key_mid_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
